// File: rtl/enc_pkg.sv
// ============================================================================
// Package : enc_pkg
// Brief   : Shared helpers for the parametrised one-hot/priority encoder.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package enc_pkg;

  // Widest request word the helper functions can handle; words are zero-extended to this.
  localparam int unsigned ENC_MAX_N = 256;

  function automatic int unsigned clog2_safe(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned prio_index(input logic [ENC_MAX_N-1:0] data,
                                             input int unsigned          n,
                                             input logic                 msb_first);
    int unsigned idx;
    idx = 0;
    if (msb_first) begin
      for (int unsigned i = 0; i < ENC_MAX_N; i++) begin
        if (i < n && data[i]) idx = i;
      end
    end else begin
      for (int i = ENC_MAX_N - 1; i >= 0; i--) begin
        if (int'(n) > i && data[i]) idx = i;
      end
    end
    return idx;
  endfunction

  function automatic logic is_multi(input logic [ENC_MAX_N-1:0] data,
                                    input int unsigned          n);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < ENC_MAX_N; i++) begin
      if (i < n && data[i]) cnt++;
    end
    return (cnt >= 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_prio_core.sv
// ============================================================================
// Module : onehot_prio_core
// Brief  : Combinational map of a request word to {code, zero, multi}.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_prio_core
  import enc_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned MSB_FIRST = 0,
  localparam int unsigned W        = clog2_safe(N)
) (
  input  logic [N-1:0] data_i,
  output logic [W-1:0] code_o,
  output logic         zero_o,
  output logic         multi_o
);

  logic [ENC_MAX_N-1:0] w_ext;
  int unsigned          w_idx;

  assign w_ext   = ENC_MAX_N'(data_i);
  assign w_idx   = prio_index(w_ext, N, (MSB_FIRST != 0));
  // The winner is always a real bit position, so the index fits in W bits and stays below N.
  assign code_o  = W'(w_idx);
  assign zero_o  = ~|data_i;
  assign multi_o = is_multi(w_ext, N);

endmodule

`default_nettype wire

// File: rtl/onehot_encoder_pipe.sv
// ============================================================================
// Module : onehot_encoder_pipe
// Brief  : Priority encoder with valid/ready input and one registered output
//          stage; optional saturating multi-hot counter under ENC_MULTI_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_encoder_pipe
  import enc_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned W        = clog2_safe(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     code,
  output logic             zero,
  output logic             multi
`ifdef ENC_MULTI_CNT_EN
  ,
  output logic [CNT_W-1:0] multi_cnt
`endif
);

  logic [W-1:0] w_code;
  logic         w_zero;
  logic         w_multi;
  logic         w_accept;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] code_q, code_d;
  logic         zero_q, zero_d;
  logic         multi_q, multi_d;

  onehot_prio_core #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .data_i  (data),
    .code_o  (w_code),
    .zero_o  (w_zero),
    .multi_o (w_multi)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    code_d      = code_q;
    zero_d      = zero_q;
    multi_d     = multi_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      code_d      = w_code;
      zero_d      = w_zero;
      multi_d     = w_multi;
    end else if (out_ready) begin
      // Drained with nothing new: payload is left as-is since it is don't-care.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      code_q      <= '0;
      zero_q      <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      zero_q      <= zero_d;
      multi_q     <= multi_d;
    end
  end

  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign zero      = zero_q;
  assign multi     = multi_q;

`ifdef ENC_MULTI_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counted on accept, not on output, and held at all-ones once saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (w_accept && w_multi && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign multi_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_onehot_encoder_pipe.sv
// ============================================================================
// Module : tb_onehot_encoder_pipe
// Brief  : Directed self-checking bench for onehot_encoder_pipe (N=8 both
//          priorities, N=5 MSB-first, multi-hot counter when enabled).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_encoder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] data8;
  logic [4:0] data5;

  logic       rdy_a, vld_a, zero_a, multi_a;
  logic [2:0] code_a;
  logic       rdy_b, vld_b, zero_b, multi_b;
  logic [2:0] code_b;
  logic       rdy_c, vld_c, zero_c, multi_c;
  logic [2:0] code_c;
`ifdef ENC_MULTI_CNT_EN
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;
  logic [7:0] cnt_c;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  onehot_encoder_pipe #(.N(8), .MSB_FIRST(0), .CNT_W(2)) u_dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .data(data8),
    .out_valid(vld_a), .out_ready(out_ready), .code(code_a), .zero(zero_a), .multi(multi_a)
`ifdef ENC_MULTI_CNT_EN
    , .multi_cnt(cnt_a)
`endif
  );

  onehot_encoder_pipe #(.N(8), .MSB_FIRST(1)) u_dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .data(data8),
    .out_valid(vld_b), .out_ready(out_ready), .code(code_b), .zero(zero_b), .multi(multi_b)
`ifdef ENC_MULTI_CNT_EN
    , .multi_cnt(cnt_b)
`endif
  );

  onehot_encoder_pipe #(.N(5), .MSB_FIRST(1)) u_dut_n5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .data(data5),
    .out_valid(vld_c), .out_ready(out_ready), .code(code_c), .zero(zero_c), .multi(multi_c)
`ifdef ENC_MULTI_CNT_EN
    , .multi_cnt(cnt_c)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data8 = '0; data5 = '0;
    step(); step();
    rst = 1'b0;
    check("rst_valid", {31'd0, vld_a}, 0);
    check("rst_code",  {29'd0, code_a}, 0);
    check("rst_zero",  {31'd0, zero_a}, 0);
    check("rst_multi", {31'd0, multi_a}, 0);
    check("rst_ready", {31'd0, rdy_a}, 1);

    // Walking one at full rate
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data8 = 8'h01 << i;
      step();
      check("walk_valid", {31'd0, vld_a}, 1);
      check("walk_code",  {29'd0, code_a}, i);
      check("walk_code_msb", {29'd0, code_b}, i);
      check("walk_zero",  {31'd0, zero_a}, 0);
      check("walk_multi", {31'd0, multi_a}, 0);
    end

    data8 = 8'h00;
    step();
    check("zero_code",  {29'd0, code_a}, 0);
    check("zero_flag",  {31'd0, zero_a}, 1);
    check("zero_multi", {31'd0, multi_a}, 0);

    data8 = 8'b0110_0100;
    step();
    check("multi_code_lsb", {29'd0, code_a}, 2);
    check("multi_code_msb", {29'd0, code_b}, 6);
    check("multi_flag_lsb", {31'd0, multi_a}, 1);
    check("multi_flag_msb", {31'd0, multi_b}, 1);
    check("multi_zero",     {31'd0, zero_a}, 0);

    // Backpressure
    data8 = 8'h10;
    step();
    check("bp_first", {29'd0, code_a}, 4);
    out_ready = 1'b0; data8 = 8'h20;
    #1 check("bp_ready_low", {31'd0, rdy_a}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_code",  {29'd0, code_a}, 4);
      check("bp_hold_valid", {31'd0, vld_a}, 1);
      check("bp_hold_ready", {31'd0, rdy_a}, 0);
    end
    out_ready = 1'b1;
    #1 check("bp_ready_high", {31'd0, rdy_a}, 1);
    step();
    check("bp_next_code",  {29'd0, code_a}, 5);
    check("bp_next_valid", {31'd0, vld_a}, 1);
    in_valid = 1'b0;
    step();
    check("drain_valid", {31'd0, vld_a}, 0);

    // Reset mid-operation
    in_valid = 1'b1; data8 = 8'h08;
    step();
    check("pre_rst_code", {29'd0, code_a}, 3);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, vld_a}, 0);
    check("mid_rst_code",  {29'd0, code_a}, 0);
    check("mid_rst_ready", {31'd0, rdy_a}, 1);
    in_valid = 1'b1; out_ready = 1'b1; data8 = 8'h40;
    step();
    check("post_rst_code",  {29'd0, code_a}, 6);
    check("post_rst_valid", {31'd0, vld_a}, 1);

    // N=5, highest bit wins
    data5 = 5'b10000;
    step();
    check("n5_top", {29'd0, code_c}, 4);
    check("n5_top_multi", {31'd0, multi_c}, 0);
    data5 = 5'b11111;
    step();
    check("n5_all_code",  {29'd0, code_c}, 4);
    check("n5_all_multi", {31'd0, multi_c}, 1);
    data5 = 5'b00110;
    step();
    check("n5_mid_code", {29'd0, code_c}, 2);
    data5 = 5'b00000;
    step();
    check("n5_zero_code", {29'd0, code_c}, 0);
    check("n5_zero_flag", {31'd0, zero_c}, 1);

`ifdef ENC_MULTI_CNT_EN
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("cnt_rst", {30'd0, cnt_a}, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data8 = 8'h03 << i;
      step();
      check("cnt_multi", {30'd0, cnt_a}, (i < 3) ? i + 1 : 3);
    end
    data8 = 8'h04;
    step();
    check("cnt_onehot", {30'd0, cnt_a}, 3);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("cnt_clear", {30'd0, cnt_a}, 0);
`endif

    in_valid = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
